// File: rtl/grant_decoder.sv
// ---------------------------------------------------------------------------
// grant_decoder
// Receiving end of the priority-encoder grant path. Accepts an encoded grant
// index over a valid/ready handshake and drives a registered one-hot grant.
// The grant is held until the grantee releases it or the hold timeout
// expires. After that, a one-cycle dead gap is enforced before the next code
// can be accepted.
//
// Optional feature: define GRANT_DECODER_PARITY_EN to add an even-parity
// check on {CODE, CODE_PAR} at the handshake.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst          synchronous reset, active-high
//   i_code         encoded grant index (3 bits)
//   i_code_valid   i_code is valid
//   o_code_ready   block can accept a code
//   i_release      grantee done; only sampled while a grant is held
//   o_gnt          one-hot grant vector (N_REQ bits)
//   o_busy         a grant is asserted
//   o_hold_cnt     completed cycles of the current grant
//   o_timeout      one-cycle pulse: grant revoked by timeout
//   o_code_err     one-cycle pulse: code >= N_REQ rejected
//   i_code_par     (parity build only) parity bit making {code,par} even
//   o_par_err      (parity build only) one-cycle pulse: parity mismatch
//
// States
//   S_IDLE  | ready for a code, no grant
//   S_GRANT | one grant bit held, hold counter running
//   S_GAP   | one dead cycle after a grant ends
// ---------------------------------------------------------------------------
module grant_decoder #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [2:0]       i_code,
    input  logic             i_code_valid,
`ifdef GRANT_DECODER_PARITY_EN
    input  logic             i_code_par,
    output logic             o_par_err,
`endif
    output logic             o_code_ready,
    input  logic             i_release,
    output logic [N_REQ-1:0] o_gnt,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_hold_cnt,
    output logic             o_timeout,
    output logic             o_code_err
);

    localparam int                CODE_W       = 3;
    localparam logic [CODE_W:0]   LP_N_REQ     = (CODE_W+1)'(N_REQ);
    // All-ones when MAX_HOLD is 0; never used in that case.
    localparam logic [CNT_W-1:0]  LP_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   w_gnt_nxt;
    logic               r_busy;
    logic               w_busy_nxt;
    logic               r_code_ready;
    logic               w_code_ready_nxt;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic [CNT_W-1:0]   w_hold_cnt_nxt;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic               r_code_err;
    logic               w_code_err_nxt;
`ifdef GRANT_DECODER_PARITY_EN
    logic               r_par_err;
    logic               w_par_err_nxt;
`endif

    logic               w_handshake;
    logic               w_par_bad;
    logic               w_code_oor;
    logic               w_timeout_hit;

    assign w_handshake   = i_code_valid && r_code_ready;
    assign w_code_oor    = ({1'b0, i_code} >= LP_N_REQ);
    assign w_timeout_hit = (MAX_HOLD != 0) && (r_hold_cnt == LP_HOLD_LAST);

`ifdef GRANT_DECODER_PARITY_EN
    assign w_par_bad = ^{i_code, i_code_par};
`else
    assign w_par_bad = 1'b0;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_gnt_nxt        = r_gnt;
        w_busy_nxt       = r_busy;
        w_code_ready_nxt = r_code_ready;
        w_hold_cnt_nxt   = r_hold_cnt;
        w_timeout_nxt    = 1'b0;
        w_code_err_nxt   = 1'b0;
`ifdef GRANT_DECODER_PARITY_EN
        w_par_err_nxt    = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                w_code_ready_nxt = 1'b1;
                if (w_handshake) begin
                    // Parity has priority over the range check.
                    if (w_par_bad) begin
`ifdef GRANT_DECODER_PARITY_EN
                        w_par_err_nxt = 1'b1;
`endif
                    end else if (w_code_oor) begin
                        w_code_err_nxt = 1'b1;
                    end else begin
                        for (int i = 0; i < N_REQ; i++) begin
                            w_gnt_nxt[i] = (i_code == CODE_W'(i));
                        end
                        w_busy_nxt       = 1'b1;
                        w_code_ready_nxt = 1'b0;
                        w_hold_cnt_nxt   = '0;
                        w_state_nxt      = S_GRANT;
                    end
                end
            end

            S_GRANT: begin
                if (i_release || w_timeout_hit) begin
                    // A release on the timeout edge suppresses the pulse.
                    w_timeout_nxt  = !i_release;
                    w_gnt_nxt      = '0;
                    w_busy_nxt     = 1'b0;
                    w_hold_cnt_nxt = '0;
                    w_state_nxt    = S_GAP;
                end else if (r_hold_cnt != {CNT_W{1'b1}}) begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end

            S_GAP: begin
                w_code_ready_nxt = 1'b1;
                w_state_nxt      = S_IDLE;
            end

            default: begin
                w_gnt_nxt        = '0;
                w_busy_nxt       = 1'b0;
                w_code_ready_nxt = 1'b0;
                w_hold_cnt_nxt   = '0;
                w_state_nxt      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_gnt        <= '0;
            r_busy       <= 1'b0;
            r_code_ready <= 1'b0;
            r_hold_cnt   <= '0;
            r_timeout    <= 1'b0;
            r_code_err   <= 1'b0;
`ifdef GRANT_DECODER_PARITY_EN
            r_par_err    <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_gnt        <= w_gnt_nxt;
            r_busy       <= w_busy_nxt;
            r_code_ready <= w_code_ready_nxt;
            r_hold_cnt   <= w_hold_cnt_nxt;
            r_timeout    <= w_timeout_nxt;
            r_code_err   <= w_code_err_nxt;
`ifdef GRANT_DECODER_PARITY_EN
            r_par_err    <= w_par_err_nxt;
`endif
        end
    end

    assign o_gnt        = r_gnt;
    assign o_busy       = r_busy;
    assign o_code_ready = r_code_ready;
    assign o_hold_cnt   = r_hold_cnt;
    assign o_timeout    = r_timeout;
    assign o_code_err   = r_code_err;
`ifdef GRANT_DECODER_PARITY_EN
    assign o_par_err    = r_par_err;
`endif

endmodule

// File: tb/tb_grant_decoder.sv
// ---------------------------------------------------------------------------
// tb_grant_decoder
// Three grant_decoder instances share one stimulus stream:
//   a: N_REQ=8, MAX_HOLD=16, CNT_W=5 (default)
//   b: N_REQ=6, MAX_HOLD=4,  CNT_W=3 (short timeout, reduced range)
//   c: N_REQ=2, MAX_HOLD=0,  CNT_W=3 (no timeout, counter saturates)
// Each instance has its own behavioural reference model. The models are
// compared against the DUT outputs on every falling edge. Directed scenarios
// come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_grant_decoder;

    logic       clk;
    logic       rst;
    logic [2:0] code;
    logic       code_valid;
    logic       code_par;
    logic       release_i;

    logic [7:0] gnt_a;
    logic [5:0] gnt_b;
    logic [1:0] gnt_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       busy_a, busy_b, busy_c;
    logic [4:0] hold_a;
    logic [2:0] hold_b, hold_c;
    logic       to_a, to_b, to_c;
    logic       ce_a, ce_b, ce_c;
    logic       pe_a, pe_b, pe_c;

    int n_checks = 0;
    int n_errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    grant_decoder #(.N_REQ(8), .MAX_HOLD(16), .CNT_W(5)) u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_valid(code_valid),
`ifdef GRANT_DECODER_PARITY_EN
        .i_code_par(code_par), .o_par_err(pe_a),
`endif
        .o_code_ready(rdy_a), .i_release(release_i), .o_gnt(gnt_a),
        .o_busy(busy_a), .o_hold_cnt(hold_a), .o_timeout(to_a), .o_code_err(ce_a)
    );

    grant_decoder #(.N_REQ(6), .MAX_HOLD(4), .CNT_W(3)) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_valid(code_valid),
`ifdef GRANT_DECODER_PARITY_EN
        .i_code_par(code_par), .o_par_err(pe_b),
`endif
        .o_code_ready(rdy_b), .i_release(release_i), .o_gnt(gnt_b),
        .o_busy(busy_b), .o_hold_cnt(hold_b), .o_timeout(to_b), .o_code_err(ce_b)
    );

    grant_decoder #(.N_REQ(2), .MAX_HOLD(0), .CNT_W(3)) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_code(code), .i_code_valid(code_valid),
`ifdef GRANT_DECODER_PARITY_EN
        .i_code_par(code_par), .o_par_err(pe_c),
`endif
        .o_code_ready(rdy_c), .i_release(release_i), .o_gnt(gnt_c),
        .o_busy(busy_c), .o_hold_cnt(hold_c), .o_timeout(to_c), .o_code_err(ce_c)
    );

`ifndef GRANT_DECODER_PARITY_EN
    assign pe_a = 1'b0;
    assign pe_b = 1'b0;
    assign pe_c = 1'b0;
`endif

    // ---------------- reference model ----------------
    // owner: index of the requester currently granted, -1 when none.
    // age:   completed cycles of the current grant.
    // gap:   in the dead cycle after a grant.
    typedef struct {
        int owner;
        int age;
        bit gap;
        bit ready;
        bit timeout;
        bit cerr;
        bit perr;
    } model_t;

    model_t ma, mb, mc;

    function automatic model_t model_reset();
        model_t m;
        m.owner = -1; m.age = 0; m.gap = 1'b0; m.ready = 1'b0;
        m.timeout = 1'b0; m.cerr = 1'b0; m.perr = 1'b0;
        return m;
    endfunction

    task automatic model_step(input int n, input int mh, input int cw, inout model_t m);
        bit par_bad;
`ifdef GRANT_DECODER_PARITY_EN
        par_bad = ^{code, code_par};
`else
        par_bad = 1'b0;
`endif
        if (rst) begin
            m = model_reset();
        end else begin
            m.timeout = 1'b0;
            m.cerr    = 1'b0;
            m.perr    = 1'b0;
            if (m.owner >= 0) begin
                if (release_i) begin
                    m.owner = -1; m.age = 0; m.gap = 1'b1;
                end else if (mh != 0 && m.age == mh - 1) begin
                    m.owner = -1; m.age = 0; m.gap = 1'b1; m.timeout = 1'b1;
                end else if (m.age < (1 << cw) - 1) begin
                    m.age = m.age + 1;
                end
                m.ready = 1'b0;
            end else if (m.gap) begin
                m.gap   = 1'b0;
                m.ready = 1'b1;
            end else begin
                if (code_valid && m.ready) begin
                    if (par_bad)            m.perr = 1'b1;
                    else if (int'(code) >= n) m.cerr = 1'b1;
                    else begin
                        m.owner = int'(code);
                        m.age   = 0;
                    end
                end
                m.ready = (m.owner < 0);
            end
        end
    endtask

    initial begin
        ma = model_reset();
        mb = model_reset();
        mc = model_reset();
    end

    always @(posedge clk) begin
        model_step(8, 16, 5, ma);
        model_step(6, 4, 3, mb);
        model_step(2, 0, 3, mc);
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_unit(input string u, input model_t m,
                              input logic [31:0] gnt, input logic busy,
                              input logic rdy, input logic [31:0] hold,
                              input logic to, input logic ce, input logic pe);
        logic [31:0] exp_gnt;
        exp_gnt = (m.owner >= 0) ? (32'd1 << m.owner) : 32'd0;
        check_eq({u, "_gnt"},    gnt,  exp_gnt);
        check_eq({u, "_onehot"}, 32'($countones(gnt) <= 1), 32'd1);
        check_eq({u, "_busy"},   32'(busy), 32'(m.owner >= 0));
        check_eq({u, "_ready"},  32'(rdy),  32'(m.ready));
        check_eq({u, "_hold"},   hold, 32'(m.age));
        check_eq({u, "_tmo"},    32'(to),   32'(m.timeout));
        check_eq({u, "_cerr"},   32'(ce),   32'(m.cerr));
        check_eq({u, "_perr"},   32'(pe),   32'(m.perr));
    endtask

    always @(negedge clk) begin
        check_unit("a", ma, 32'(gnt_a), busy_a, rdy_a, 32'(hold_a), to_a, ce_a, pe_a);
        check_unit("b", mb, 32'(gnt_b), busy_b, rdy_b, 32'(hold_b), to_b, ce_b, pe_b);
        check_unit("c", mc, 32'(gnt_c), busy_c, rdy_c, 32'(hold_c), to_c, ce_c, pe_c);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_code(input logic [2:0] c);
        code     = c;
        code_par = ^c;
    endtask

    task automatic release_pulse();
        release_i = 1'b1;
        step(1);
        release_i = 1'b0;
        step(2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst        = 1'b1;
        code       = 3'd0;
        code_par   = 1'b0;
        code_valid = 1'b0;
        release_i  = 1'b0;

        // Reset for two cycles.
        step(2);
        check_eq("rst_gnt",   32'(gnt_a), 32'd0);
        check_eq("rst_ready", 32'(rdy_a), 32'd0);
        check_eq("rst_busy",  32'(busy_a), 32'd0);
        rst = 1'b0;
        step(1);
        check_eq("post_rst_ready", 32'(rdy_a), 32'd1);

        // Scenario 1: code 5.
        set_code(3'd5);
        code_valid = 1'b1;
        step(1);
        code_valid = 1'b0;
        check_eq("s1_gnt_a",  32'(gnt_a), 32'h20);
        check_eq("s1_busy_a", 32'(busy_a), 32'd1);
        check_eq("s1_rdy_a",  32'(rdy_a), 32'd0);
        check_eq("s1_hold_a", 32'(hold_a), 32'd0);
        check_eq("s1_cerr_c", 32'(ce_c), 32'd1);

        // Scenario 2: hold count 0..3, then release. For b this release
        // lands on the timeout edge and must suppress the pulse.
        step(1); check_eq("s2_hold1", 32'(hold_a), 32'd1);
        step(1); check_eq("s2_hold2", 32'(hold_a), 32'd2);
        step(1); check_eq("s2_hold3", 32'(hold_a), 32'd3);
        check_eq("s4_hold_b3", 32'(hold_b), 32'd3);
        release_i = 1'b1;
        step(1);
        release_i = 1'b0;
        check_eq("s2_gnt_off", 32'(gnt_a), 32'd0);
        check_eq("s2_gap_rdy", 32'(rdy_a), 32'd0);
        check_eq("s4_gnt_b",   32'(gnt_b), 32'd0);
        check_eq("s4_no_tmo",  32'(to_b),  32'd0);
        step(1);
        check_eq("s2_rdy_back", 32'(rdy_a), 32'd1);

        // Scenario 3: code 0, never released; b times out after 4 cycles.
        set_code(3'd0);
        code_valid = 1'b1;
        step(1);
        code_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq("s3_gnt_b_on", 32'(gnt_b), 32'h01);
            check_eq("s3_tmo_low",  32'(to_b),  32'd0);
            step(1);
        end
        check_eq("s3_gnt_b_off", 32'(gnt_b), 32'd0);
        check_eq("s3_tmo_pulse", 32'(to_b),  32'd1);
        check_eq("s3_rdy_gap",   32'(rdy_b), 32'd0);
        step(1);
        check_eq("s3_tmo_clear", 32'(to_b),  32'd0);
        check_eq("s3_rdy_back",  32'(rdy_b), 32'd1);
        release_pulse();

        // Out-of-range code 7 for b (N_REQ=6); accepted by a.
        set_code(3'd7);
        code_valid = 1'b1;
        step(1);
        code_valid = 1'b0;
        check_eq("oor_cerr_b", 32'(ce_b),  32'd1);
        check_eq("oor_gnt_b",  32'(gnt_b), 32'd0);
        check_eq("oor_rdy_b",  32'(rdy_b), 32'd1);
        check_eq("oor_gnt_a",  32'(gnt_a), 32'h80);
        step(1);
        check_eq("oor_cerr_clr", 32'(ce_b), 32'd0);
        release_pulse();

        // Scenario 5: reset in the middle of a grant.
        set_code(3'd2);
        code_valid = 1'b1;
        step(1);
        code_valid = 1'b0;
        step(1);
        check_eq("s5_hold1", 32'(hold_a), 32'd1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_eq("s5_gnt",  32'(gnt_a),  32'd0);
        check_eq("s5_busy", 32'(busy_a), 32'd0);
        check_eq("s5_rdy",  32'(rdy_a),  32'd0);
        check_eq("s5_hold", 32'(hold_a), 32'd0);
        check_eq("s5_tmo",  32'(to_a),   32'd0);
        step(1);
        check_eq("s5_rdy_back", 32'(rdy_a), 32'd1);

`ifdef GRANT_DECODER_PARITY_EN
        // Scenario 6: bad parity, then good parity for code 3.
        code       = 3'd3;
        code_par   = 1'b1;
        code_valid = 1'b1;
        step(1);
        check_eq("s6_perr",   32'(pe_a),  32'd1);
        check_eq("s6_gnt0",   32'(gnt_a), 32'd0);
        check_eq("s6_rdy",    32'(rdy_a), 32'd1);
        check_eq("s6_cerr_c", 32'(ce_c),  32'd0);
        code_par = 1'b0;
        step(1);
        code_valid = 1'b0;
        check_eq("s6_gnt", 32'(gnt_a), 32'h08);
        check_eq("s6_perr_clr", 32'(pe_a), 32'd0);
        release_pulse();
`endif

        // Randomized traffic; the per-cycle monitor does the checking.
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst        = ($urandom_range(0, 249) == 0);
            code_valid = $urandom_range(0, 1);
            code       = 3'($urandom_range(0, 7));
            code_par   = (^code) ^ ($urandom_range(0, 7) == 0);
            if (cyc < 2000) release_i = ($urandom_range(0, 3) == 0);
            else            release_i = ($urandom_range(0, 39) == 0);
            step(1);
        end

        rst        = 1'b0;
        code_valid = 1'b0;
        release_i  = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
